// File: rtl/mem_stage_unit_pkg.sv
// rv32i_types: memory-stage FSM states and the mask_sel encodings shared with the control generator
package rv32i_types;
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} mem_state_t;
  localparam logic [2:0] mask_w = 3'd0;
  localparam logic [2:0] mask_h = 3'd1;
  localparam logic [2:0] mask_hu = 3'd2;
  localparam logic [2:0] mask_b = 3'd3;
  localparam logic [2:0] mask_bu = 3'd4;
endpackage

// File: rtl/mem_stage_unit_load_align_extend.sv
// load_align_extend: shifts the addressed lanes of a cache word down and sign/zero-extends them
module load_align_extend
  import rv32i_types::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [2:0]  mask_sel,
  output logic [31:0] result
);
  logic [31:0] w;
  assign w = rdata >> {offset, 3'b000};
  always_comb begin
    result = mask_sel == mask_h  ? {{16{w[15]}}, w[15:0]} :
             mask_sel == mask_hu ? {16'h0000, w[15:0]} :
             mask_sel == mask_b  ? {{24{w[7]}}, w[7:0]} :
             mask_sel == mask_bu ? {24'h000000, w[7:0]} : w;
  end
endmodule

// File: rtl/mem_stage_unit.sv
// mem_stage_unit: turns MEM-stage control into a registered data-cache request,
// stalls while it is outstanding and returns aligned, extended load data
module mem_stage_unit
  import rv32i_types::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [3:0]        mem_byte_enable,
  input  logic [2:0]        mask_sel,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] store_data,
  input  logic              dmem_resp,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              dmem_read,
  output logic              dmem_write,
  output logic [ADDR_W-1:0] dmem_address,
  output logic [DATA_W-1:0] dmem_wdata,
  output logic [3:0]        dmem_byte_enable,
  output logic              stall_mem,
  output logic [DATA_W-1:0] load_data,
  output logic              misalign
);
  mem_state_t state_q, state_d;
  logic rd_q, wr_q, mis_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, load_q, ext;
  logic [3:0] be_q;
  logic [2:0] mask_q;
  logic [1:0] off_q;
  logic pending, is_word, is_half, misaligned, reject, issue, take_resp;
  assign pending = in_valid && (mem_read || mem_write);
  // stores size themselves by byte enable, loads by mask_sel; a write beats a simultaneous read
  assign is_word = mem_write ? mem_byte_enable == 4'b1111 : !(mask_sel inside {mask_h, mask_hu, mask_b, mask_bu});
  assign is_half = mem_write ? mem_byte_enable == 4'b0011 : mask_sel inside {mask_h, mask_hu};
  assign misaligned = (is_word && addr[1:0] != 2'b00) || (is_half && addr[0]);
  assign reject = state_q == IDLE && pending && misaligned;
  assign issue = state_q == IDLE && pending && !misaligned;
  assign take_resp = state_q == ACCESS && dmem_resp;
  always_comb begin
    state_d = issue ? ACCESS : take_resp ? DONE : state_q == DONE ? IDLE : state_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rd_q <= 1'b0;
      wr_q <= 1'b0;
      mis_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      load_q <= '0;
      be_q <= '0;
      mask_q <= mask_w;
      off_q <= '0;
    end else begin
      state_q <= state_d;
      mis_q <= reject;
      if (issue) begin
        rd_q <= !mem_write;
        wr_q <= mem_write;
        addr_q <= {addr[ADDR_W-1:2], 2'b00};
        be_q <= mem_byte_enable << addr[1:0];
        wdata_q <= store_data << {addr[1:0], 3'b000};
        mask_q <= mask_sel;
        off_q <= addr[1:0];
      end else if (take_resp) begin
        rd_q <= 1'b0;
        wr_q <= 1'b0;
      end
      if (take_resp && rd_q) load_q <= ext;
      else if (reject) load_q <= '0;
    end
  end
  load_align_extend u_align (
    .rdata(dmem_rdata),
    .offset(off_q),
    .mask_sel(mask_q),
    .result(ext)
  );
  assign stall_mem = issue || state_q == ACCESS;
  assign dmem_read = rd_q;
  assign dmem_write = wr_q;
  assign dmem_address = addr_q;
  assign dmem_wdata = wdata_q;
  assign dmem_byte_enable = be_q;
  assign load_data = load_q;
  assign misalign = mis_q;
endmodule

// File: tb/tb_mem_stage_unit.sv
// tb_mem_stage_unit: transaction-level reference model with a per-cycle output comparator
module tb_mem_stage_unit;
  logic clk = 1'b0;
  logic rst, in_valid, mem_read, mem_write, dmem_resp;
  logic [3:0] mem_byte_enable;
  logic [2:0] mask_sel;
  logic [31:0] addr, store_data, dmem_rdata;
  logic dmem_read, dmem_write, stall_mem, misalign;
  logic [31:0] dmem_address, dmem_wdata, load_data;
  logic [3:0] dmem_byte_enable;
  int n_chk = 0;
  int n_fail = 0;
  logic chk_en = 1'b0;
  logic e_rd, e_wr, e_stall, e_mis;
  logic [31:0] e_addr, e_wd, e_ld;
  logic [3:0] e_be;

  mem_stage_unit dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .mem_read(mem_read), .mem_write(mem_write),
    .mem_byte_enable(mem_byte_enable), .mask_sel(mask_sel), .addr(addr), .store_data(store_data),
    .dmem_resp(dmem_resp), .dmem_rdata(dmem_rdata), .dmem_read(dmem_read), .dmem_write(dmem_write),
    .dmem_address(dmem_address), .dmem_wdata(dmem_wdata), .dmem_byte_enable(dmem_byte_enable),
    .stall_mem(stall_mem), .load_data(load_data), .misalign(misalign)
  );

  always #5 clk = ~clk;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) if (chk_en) begin
    chk("dmem_read", 32'(dmem_read), 32'(e_rd));
    chk("dmem_write", 32'(dmem_write), 32'(e_wr));
    chk("stall_mem", 32'(stall_mem), 32'(e_stall));
    chk("misalign", 32'(misalign), 32'(e_mis));
    chk("dmem_address", dmem_address, e_addr);
    chk("dmem_wdata", dmem_wdata, e_wd);
    chk("dmem_byte_enable", 32'(dmem_byte_enable), 32'(e_be));
    chk("load_data", load_data, e_ld);
  end

  function automatic logic [31:0] m_load(logic [31:0] rd, logic [1:0] off, logic [2:0] ms);
    logic [31:0] w;
    logic signed [31:0] s;
    w = rd >> (8 * off);
    case (ms)
      3'd1: begin s = $signed(w[15:0]); return s; end
      3'd2: return {16'h0, w[15:0]};
      3'd3: begin s = $signed(w[7:0]); return s; end
      3'd4: return {24'h0, w[7:0]};
      default: return w;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic txn(logic v, logic rd, logic wr, logic [3:0] be, logic [2:0] ms,
                     logic [31:0] a, logic [31:0] sd, int dly, logic [31:0] rdata);
    bit pend, mis;
    int sz;
    logic [3:0] sbe;
    pend = v && (rd || wr);
    sz = wr ? (be == 4'hF ? 4 : be == 4'h3 ? 2 : 1) : ((ms == 1 || ms == 2) ? 2 : (ms == 3 || ms == 4) ? 1 : 4);
    mis = pend && ((sz == 4 && a[1:0] != 0) || (sz == 2 && a[0]));
    in_valid = v; mem_read = rd; mem_write = wr; mem_byte_enable = be; mask_sel = ms;
    addr = a; store_data = sd; dmem_resp = 1'($urandom); dmem_rdata = $urandom;
    e_rd = 0; e_wr = 0; e_mis = 0; e_stall = pend && !mis;
    tick();
    if (!pend) return;
    if (mis) begin
      in_valid = 0; dmem_resp = 0; e_mis = 1; e_ld = 0; e_stall = 0;
      tick();
      return;
    end
    sbe = be << a[1:0];
    e_addr = {a[31:2], 2'b00}; e_be = sbe; e_wd = sd << (8 * a[1:0]);
    for (int k = 0; k <= dly; k++) begin
      e_rd = rd && !wr; e_wr = wr; e_stall = 1;
      dmem_resp = (k == dly);
      dmem_rdata = (k == dly) ? rdata : $urandom;
      tick();
    end
    e_rd = 0; e_wr = 0; e_stall = 0;
    if (!wr) e_ld = m_load(rdata, a[1:0], ms);
    dmem_resp = 1'($urandom); dmem_rdata = $urandom;
    tick();
  endtask

  initial begin
    logic [3:0] bes [3] = '{4'hF, 4'h3, 4'h1};
    rst = 1; in_valid = 0; mem_read = 0; mem_write = 0; mem_byte_enable = 0; mask_sel = 0;
    addr = 0; store_data = 0; dmem_resp = 0; dmem_rdata = 0;
    tick(); tick();
    e_rd = 0; e_wr = 0; e_stall = 0; e_mis = 0; e_addr = 0; e_wd = 0; e_ld = 0; e_be = 0;
    chk_en = 1;
    tick();
    rst = 0;
    chk("model_lb", m_load(32'h12F45678, 2'd2, 3'd3), 32'hFFFFFFF4);
    chk("model_lhu", m_load(32'h8001ABCD, 2'd2, 3'd2), 32'h00008001);
    txn(1, 0, 1, 4'hF, 0, 32'h1000, 32'hDEADBEEF, 1, 0);
    chk("sw_wdata", dmem_wdata, 32'hDEADBEEF);
    chk("sw_address", dmem_address, 32'h1000);
    txn(1, 0, 1, 4'h1, 0, 32'h2003, 32'h000000A5, 0, 0);
    chk("sb_wdata", dmem_wdata, 32'hA5000000);
    chk("sb_be", 32'(dmem_byte_enable), 32'h8);
    chk("sb_address", dmem_address, 32'h2000);
    txn(1, 1, 0, 4'h1, 3, 32'h3002, 0, 0, 32'h12F45678);
    chk("lb_load", load_data, 32'hFFFFFFF4);
    txn(1, 1, 0, 4'h1, 4, 32'h3002, 0, 2, 32'h12F45678);
    chk("lbu_load", load_data, 32'h000000F4);
    txn(1, 1, 0, 4'h3, 1, 32'h4002, 0, 0, 32'h8001ABCD);
    chk("lh_load", load_data, 32'hFFFF8001);
    txn(1, 1, 0, 4'h3, 2, 32'h4002, 0, 1, 32'h8001ABCD);
    chk("lhu_load", load_data, 32'h00008001);
    txn(1, 1, 0, 4'hF, 0, 32'h5001, 0, 0, 0);
    chk("misalign_load", load_data, 32'h0);
    txn(1, 1, 1, 4'hF, 3, 32'h5004, 32'h11223344, 0, 32'hFFFFFFFF);
    chk("write_wins_load", load_data, 32'h0);
    for (int i = 0; i < 200; i++)
      txn(1'($urandom_range(0, 7) != 0), 1'($urandom), 1'($urandom), bes[$urandom_range(0, 2)],
          3'($urandom_range(0, 7)), $urandom, $urandom, $urandom_range(0, 3), $urandom);
    rst = 1; tick(); rst = 0;
    e_rd = 0; e_wr = 0; e_stall = 0; e_mis = 0; e_addr = 0; e_wd = 0; e_ld = 0; e_be = 0;
    in_valid = 1; mem_read = 1; mem_write = 0; mem_byte_enable = 4'hF; mask_sel = 0;
    addr = 32'h6000; store_data = 32'h0; dmem_resp = 0; e_stall = 1;
    tick();
    e_rd = 1; e_addr = 32'h6000; e_be = 4'hF; e_wd = 0; rst = 1;
    tick();
    rst = 0; in_valid = 0; dmem_resp = 1; dmem_rdata = 32'hFFFFFFFF;
    e_rd = 0; e_stall = 0; e_addr = 0; e_be = 0;
    tick();
    tick();
    chk("rst_access_read", 32'(dmem_read), 32'h0);
    chk("rst_access_load", load_data, 32'h0);
    chk_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
